// File: rtl/aes_encrypt_ctrl_pkg.sv
// Shared definitions for the AES-128 encryption controller.
//   - state_t    : controller FSM states
//   - block_t    : 128-bit AES block, byte 0 in [127:120]
//   - NUM_ROUNDS : AES-128 round count
//   - RCON       : round-constant ROM indexed by round number
//   - xtime / gf_mul / sbox / mix_col : GF(2^8) helpers used by the round logic
package aes_encrypt_ctrl_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Entry 0 and 11..15 are never used by a real round; they are zero so the
   // ROM can be indexed directly by the 4-bit round counter.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // S-box computed rather than tabulated: inverse as b^254 (product of
   // b^2, b^4 .. b^128), then the AES affine transform. 0 maps to 0 before
   // the affine step, as required.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = b;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // MixColumns on one column, row 0 in the top byte.
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/addRoundKey.sv
// AddRoundKey: XOR of the state with a round key.
//   i_state : input state
//   i_key   : round key
//   o_state : i_state ^ i_key
module addRoundKey (
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   output logic [127:0] o_state
);

   assign o_state = i_state ^ i_key;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step (combinational): previous round key -> next.
//   key_in  : round key r-1 as words w0..w3 (w0 in [127:96])
//   rcon    : round constant for round r
//   key_out : round key r as words w4..w7
module aes_key_step
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w_w0, w_w1, w_w2, w_w3;
   logic [31:0] w_rot, w_sub;
   logic [31:0] w_w4, w_w5, w_w6, w_w7;

   assign {w_w0, w_w1, w_w2, w_w3} = key_in;

   assign w_rot = {w_w3[23:0], w_w3[31:24]};
   assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};

   assign w_w4 = w_w0 ^ w_sub ^ {rcon, 24'h000000};
   assign w_w5 = w_w1 ^ w_w4;
   assign w_w6 = w_w2 ^ w_w5;
   assign w_w7 = w_w3 ^ w_w6;

   assign key_out = {w_w4, w_w5, w_w6, w_w7};

endmodule

// File: rtl/encryptRound.sv
// One full AES round (rounds 1..9): SubBytes, ShiftRows, MixColumns, AddRoundKey.
//   i_state : state entering the round
//   i_key   : round key for this round
//   o_state : state leaving the round
module encryptRound
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   output logic [127:0] o_state
);

   logic [127:0] w_sub;
   logic [127:0] w_shift;
   logic [127:0] w_mix;

   subBytes u_sub (
      .i_state (i_state),
      .o_state (w_sub)
   );

   shiftRows u_shift (
      .i_state (w_sub),
      .o_state (w_shift)
   );

   always_comb begin
      w_mix = '0;
      for (int c = 0; c < 4; c++) begin
         w_mix[127 - 32*c -: 32] = mix_col(w_shift[127 - 32*c -: 32]);
      end
   end

   addRoundKey u_ark (
      .i_state (w_mix),
      .i_key   (i_key),
      .o_state (o_state)
   );

endmodule

// File: rtl/shiftRows.sv
// ShiftRows: row r of the column-major state is rotated left by r bytes.
//   i_state : input state (byte k at [127-8k -: 8], row k%4, column k/4)
//   o_state : shifted state
module shiftRows (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);

   always_comb begin
      o_state = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o_state[127 - 8*(r + 4*c) -: 8] = i_state[127 - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
   end

endmodule

// File: rtl/subBytes.sv
// SubBytes: applies the AES S-box to all 16 bytes of the state.
//   i_state : input state
//   o_state : substituted state
module subBytes
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);

   always_comb begin
      // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
      o_state = '0;
      for (int b = 0; b < 16; b++) begin
         o_state[b*8 +: 8] = sbox(i_state[b*8 +: 8]);
      end
   end

endmodule

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : plaintext + key handshake (accepted only in IDLE)
//   in_data, in_key     : plaintext and cipher key, byte 0 in [127:120]
//   out_valid/out_ready : ciphertext handshake, result held until taken
//   out_data            : ciphertext, forced to 0 while out_valid is low
//   busy                : high whenever the FSM is not in IDLE
// Accept edge loads the round-0 AddRoundKey; 10 ROUND edges follow, the
// 10th lands in DONE with out_valid set.
module aes_encrypt_ctrl #(
   parameter int NUM_ROUNDS = aes_encrypt_ctrl_pkg::NUM_ROUNDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   import aes_encrypt_ctrl_pkg::*;

   state_t     r_state;
   logic [3:0] r_rnd;
   block_t     r_block;
   block_t     r_key;
   logic       r_in_ready;
   logic       r_out_valid;
   logic       r_busy;

   block_t     w_rk;
   block_t     w_mid;
   block_t     w_fsub;
   block_t     w_fshift;
   block_t     w_final;
   logic       w_last;

   aes_key_step u_key (
      .key_in  (r_key),
      .rcon    (RCON[r_rnd]),
      .key_out (w_rk)
   );

   encryptRound u_round (
      .i_state (r_block),
      .i_key   (w_rk),
      .o_state (w_mid)
   );

   // Final round: same primitives without MixColumns.
   subBytes u_fsub (
      .i_state (r_block),
      .o_state (w_fsub)
   );

   shiftRows u_fshift (
      .i_state (w_fsub),
      .o_state (w_fshift)
   );

   addRoundKey u_fark (
      .i_state (w_fshift),
      .i_key   (w_rk),
      .o_state (w_final)
   );

   assign w_last = (r_rnd == 4'(NUM_ROUNDS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset as well, so an aborted job leaves no key or partial state behind.
         r_state     <= IDLE;
         r_rnd       <= 4'd0;
         r_block     <= '0;
         r_key       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
         case (r_state)
            IDLE: begin
               // in_ready comes up on the first edge after reset release.
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_block    <= in_data ^ in_key;
                  r_key      <= in_key;
                  r_rnd      <= 4'd1;
                  r_state    <= ROUND;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ROUND: begin
               r_key <= w_rk;
               if (w_last) begin
                  // Counter stays at the last round; it is cleared on handshake.
                  r_block     <= w_final;
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_block <= w_mid;
                  r_rnd   <= r_rnd + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_rnd       <= 4'd0;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_data  = r_out_valid ? r_block : '0;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Self-checking bench for aes_encrypt_ctrl: FIPS-197 vectors, random jobs
// against a byte-array AES model, backpressure, busy-time noise, back-to-back
// spacing and mid-job reset.
module tb_aes_encrypt_ctrl;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data   = '0;
   logic [127:0] in_key    = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] out_data;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0] sb [256];

   int           cyc = 0;
   int           acc_cyc [$];
   logic [127:0] out_q [$];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_encrypt_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Accept and output handshake log, sampled with pre-edge values.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) out_q.push_back(out_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "time limit reached");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = tb_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ w[c][31 - 8*r -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb[s[(r)][(c + r) % 4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rd < 10)
                  s[r][c] = tb_mul(8'h02, t[r][c]) ^ tb_mul(8'h03, t[(r+1)%4][c])
                          ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ w[4*rd + c][31 - 8*r -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127 - 8*(r + 4*c) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- helpers ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full job: offer, accept, wait for result, optional backpressure, handshake.
   task automatic do_job(input logic [127:0] key, input logic [127:0] pt,
                         input int hold, input bit noisy, input string tag);
      logic [127:0] exp;
      int           lat;
      bit           ok;
      exp = aes_ref(key, pt);
      lat = 0;
      while (in_ready !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_ready"}, 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = pt;
      in_key   = key;
      tick();
      in_valid = 1'b0;
      in_data  = rand128();
      in_key   = rand128();
      lat = 0;
      ok  = 1'b1;
      while (out_valid !== 1'b1 && lat < 20) begin
         if (noisy) begin
            in_valid = 1'($urandom);
            in_data  = rand128();
            in_key   = rand128();
         end
         tick();
         lat++;
         if (out_valid !== 1'b1 && (in_ready !== 1'b0 || busy !== 1'b1 || out_data !== '0)) ok = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, 128'(lat), 128'd10);
      check({tag, "_round_flags"}, 128'(ok), 128'd1);
      check({tag, "_data"}, out_data, exp);
      ok = 1'b1;
      repeat (hold) begin
         tick();
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      check({tag, "_hold"}, 128'(ok), 128'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_post_flags"}, 128'({out_valid, in_ready, busy}), 128'd2);
      check({tag, "_post_data"}, out_data, 128'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] bk [4];
      logic [127:0] bp [4];
      int           n;
      bit           ok;

      build_sbox();

      // Reset state, release mid-cycle, in_ready on first edge after release.
      #2;
      check("reset_flags", 128'({in_ready, out_valid, busy}), 128'd0);
      check("reset_data", out_data, 128'd0);
      #20;
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 128'(in_ready), 128'd0);
      tick();
      check("ready_after_edge", 128'(in_ready), 128'd1);

      // Model anchored on the published vectors before it judges random jobs.
      check("model_c1", aes_ref(C1_KEY, C1_PT), C1_CT);
      check("model_b", aes_ref(B_KEY, B_PT), B_CT);

      do_job(C1_KEY, C1_PT, 0, 1'b0, "fips_c1");
      do_job(B_KEY, B_PT, 7, 1'b0, "fips_b_bp7");

      for (int i = 0; i < 2; i++) do_job(rand128(), rand128(), 1, 1'b1, "noisy");
      for (int i = 0; i < 4; i++) do_job(rand128(), rand128(), int'($urandom_range(0, 3)), 1'b0, "random");

      // Back-to-back with out_ready held high.
      acc_cyc.delete();
      out_q.delete();
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         bk[j]    = rand128();
         bp[j]    = rand128();
         in_valid = 1'b1;
         in_data  = bp[j];
         in_key   = bk[j];
         n = 0;
         while (acc_cyc.size() < j + 1 && n < 30) begin
            tick();
            n++;
         end
      end
      in_valid = 1'b0;
      repeat (14) tick();
      out_ready = 1'b0;
      check("b2b_accepts", 128'(acc_cyc.size()), 128'd4);
      for (int j = 0; j < 3; j++)
         check("b2b_spacing", 128'((acc_cyc.size() > j + 1) ? acc_cyc[j+1] - acc_cyc[j] : -1), 128'd12);
      for (int j = 0; j < 4; j++)
         check("b2b_data", (out_q.size() > j) ? out_q[j] : 128'hx, aes_ref(bk[j], bp[j]));

      // Mid-job reset at round 5.
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      in_valid = 1'b1;
      in_data  = C1_PT;
      in_key   = C1_KEY;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_flags", 128'({in_ready, out_valid, busy}), 128'd0);
      check("abort_data", out_data, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (15) begin
         tick();
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      check("abort_no_result", 128'(ok), 128'd1);
      do_job(C1_KEY, C1_PT, 0, 1'b0, "c1_after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_ctrl.md
AES_ENCRYPT_CTRL -- requirements
Module: aes_encrypt_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, giving the AES-128 round count; only 10 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: plaintext/key offer valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a new job.
REQ-006 SHALL have port in_data, input, 128 bits: plaintext, byte 0 in [127:120].
REQ-007 SHALL have port in_key, input, 128 bits: cipher key, same byte order.
REQ-008 SHALL have port out_valid, output, 1 bit: ciphertext valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts ciphertext.
REQ-010 SHALL have port out_data, output, 128 bits: ciphertext.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ROUND and DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept occurs on an edge where in_valid && in_ready.
REQ-014 On accept, SHALL load state_reg = in_data ^ in_key, key_reg = in_key, rnd = 1, and go to ROUND.
REQ-015 In ROUND, each edge SHALL compute rk = next round key from key_reg and rcon[rnd], then write it to key_reg.
REQ-016 In ROUND with rnd 1..9, each edge SHALL set state_reg = SubBytes, ShiftRows, MixColumns, then AddRoundKey(rk).
REQ-017 In ROUND with rnd 10, the edge SHALL apply SubBytes, ShiftRows and AddRoundKey(rk) with no MixColumns, then go to DONE.
REQ-018 SHALL increment rnd by one per ROUND edge; rnd is 4 bits and never exceeds 10.
REQ-019 SHALL use rcon sequence 01,02,04,08,10,20,40,80,1B,36 for rnd 1..10, held in a ROM.
REQ-020 Key step: SHALL compute w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6.
REQ-021 Latency: out_valid SHALL go high exactly 10 cycles after the accept edge.
REQ-022 In DONE, SHALL hold out_valid = 1 and out_data = state_reg stable until out_ready.
REQ-023 On an edge in DONE with out_ready = 1, SHALL return to IDLE.
REQ-024 In the cycle after the return to IDLE, in_ready SHALL be 1, giving a minimum spacing of 12 cycles between accepts.
REQ-025 SHALL ignore in_valid outside IDLE and not sample in_data or in_key then.
REQ-026 in_data and in_key SHALL be needed only on the accept edge.
REQ-027 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-028 On rst_n low, SHALL asynchronously force: FSM to IDLE, rnd 0, state_reg 0, key_reg 0.
REQ-029 On rst_n low, outputs SHALL be in_ready 0, out_valid 0, out_data 0, busy 0.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset mid-job (ROUND or DONE) SHALL abort the job; no partial result is ever presented.

Structure
REQ-032 A shared package SHALL hold: the FSM state enum, the rcon table, NUM_ROUNDS, and the 128-bit block type.
REQ-033 The round datapath SHALL reuse the existing encryptRound module for rounds 1..9.
REQ-034 The final round SHALL reuse the existing subBytes, shiftRows and addRoundKey modules.
REQ-035 Key scheduling SHALL be one sub-module, aes_key_step (key_in, rcon -> key_out), combinational only.

Verification
REQ-036 Reset and idle: assert rst_n low mid-clock -> in_ready, out_valid and busy drop at once; first edge after release -> in_ready = 1.
REQ-037 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid 10 cycles after accept.
REQ-038 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32.
REQ-039 Backpressure: hold out_ready = 0 for 7 cycles -> out_data stable and in_ready = 0 throughout; single-cycle handshake then IDLE.
REQ-040 Busy stimulus: toggle in_valid and change in_data during ROUND -> no effect on the result.
REQ-041 Back-to-back jobs with out_ready = 1 -> accepts spaced exactly 12 cycles apart.
REQ-042 Mid-job abort: reset at rnd 5 -> no out_valid; the next job gives the correct C.1 result.
